// File: rtl/mem_control_pkg.sv
// Shared memory-controller definitions: default DRAM geometry, derived address
// field widths and the packed completion record used on the DRAM return path.
package mem_control_pkg;

    localparam int DEF_ROW_BITS        = 8;
    localparam int DEF_COL_BITS        = 4;
    localparam int DEF_BANK_GROUPS     = 4;
    localparam int DEF_BANKS_PER_GROUP = 2;
    localparam int DEF_DATA_WIDTH      = 64;

    localparam int BANK_GRP_BITS = $clog2(DEF_BANK_GROUPS);
    localparam int BANK_BITS     = $clog2(DEF_BANKS_PER_GROUP);
    localparam int LOWER_BITS    = DEF_COL_BITS + BANK_BITS + BANK_GRP_BITS;

    // Field order matches the physical address layout, row in the MSBs.
    typedef struct packed {
        logic [DEF_ROW_BITS-1:0]   row;
        logic [BANK_GRP_BITS-1:0]  bg;
        logic [BANK_BITS-1:0]      ba;
        logic [DEF_COL_BITS-1:0]   col;
        logic [DEF_DATA_WIDTH-1:0] data;
    } completion_t;

    // Width of the {bg, ba, col} slice sitting below the row field.
    function automatic int lower_bits(input int col_bits, input int bank_groups,
                                      input int banks_per_group);
        return col_bits + $clog2(bank_groups) + $clog2(banks_per_group);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Valid/ready FIFO with registered storage, no write-to-read bypass and a
// zero-masked head while empty.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Readiness depends only on occupancy, so a pop never frees a slot for the same edge.
    assign wr_ready = (count != FULL);
    assign rd_valid = (count != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; stale contents are hidden by the empty mask below.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mem_addr_composer.sv
// Queues DRAM read completions and rebuilds the physical bus address from the
// returned {row, bg, ba, col} fields before handing them back to the bus.
module mem_addr_composer
    import mem_control_pkg::*;
#(
    parameter int ROW_BITS        = DEF_ROW_BITS,
    parameter int COL_BITS        = DEF_COL_BITS,
    parameter int PADDR_BITS      = 19,
    parameter int BANK_GROUPS     = DEF_BANK_GROUPS,
    parameter int BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               dram_valid_in,
    output logic                               dram_ready_out,
    input  logic [ROW_BITS-1:0]                row_in,
    input  logic [COL_BITS-1:0]                col_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]     bg_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] ba_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               mem_bus_valid_out,
    input  logic                               mem_bus_ready_in,
    output logic [PADDR_BITS-1:0]              mem_bus_addr_out,
    output logic [DATA_WIDTH-1:0]              mem_bus_data_out,
    output logic [$clog2(DEPTH):0]             count_out
);

    localparam int BG_W    = $clog2(BANK_GROUPS);
    localparam int BA_W    = $clog2(BANKS_PER_GROUP);
    localparam int LO_W    = lower_bits(COL_BITS, BANK_GROUPS, BANKS_PER_GROUP);
    localparam int ENTRY_W = ROW_BITS + LO_W + DATA_WIDTH;

    // Same layout as completion_t, re-sized to this instance's geometry.
    typedef struct packed {
        logic [ROW_BITS-1:0]   row;
        logic [BG_W-1:0]       bg;
        logic [BA_W-1:0]       ba;
        logic [COL_BITS-1:0]   col;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t push_entry;
    entry_t head_entry;

    assign push_entry = {row_in, bg_in, ba_in, col_in, data_in};

    resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .wr_valid (dram_valid_in),
        .wr_ready (dram_ready_out),
        .wr_data  (push_entry),
        .rd_valid (mem_bus_valid_out),
        .rd_ready (mem_bus_ready_in),
        .rd_data  (head_entry),
        .count    (count_out)
    );

    // Zero-extension fills the bus bits above the row field.
    assign mem_bus_addr_out = PADDR_BITS'({head_entry.row, head_entry.bg,
                                           head_entry.ba, head_entry.col});
    assign mem_bus_data_out = head_entry.data;

endmodule

// File: tb/tb_mem_addr_composer.sv
// Directed self-checking bench for mem_addr_composer with default parameters.
module tb_mem_addr_composer;
    import mem_control_pkg::*;

    localparam int ROW_BITS   = 8;
    localparam int COL_BITS   = 4;
    localparam int PADDR_BITS = 19;
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 4;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  dram_valid_in;
    logic                  dram_ready_out;
    logic [ROW_BITS-1:0]   row_in;
    logic [COL_BITS-1:0]   col_in;
    logic [1:0]            bg_in;
    logic [0:0]            ba_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  mem_bus_valid_out;
    logic                  mem_bus_ready_in;
    logic [PADDR_BITS-1:0] mem_bus_addr_out;
    logic [DATA_WIDTH-1:0] mem_bus_data_out;
    logic [2:0]            count_out;

    int checks = 0;
    int errors = 0;

    mem_addr_composer #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PADDR_BITS(PADDR_BITS),
        .BANK_GROUPS(4), .BANKS_PER_GROUP(2), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dram_valid_in(dram_valid_in), .dram_ready_out(dram_ready_out),
        .row_in(row_in), .col_in(col_in), .bg_in(bg_in), .ba_in(ba_in), .data_in(data_in),
        .mem_bus_valid_out(mem_bus_valid_out), .mem_bus_ready_in(mem_bus_ready_in),
        .mem_bus_addr_out(mem_bus_addr_out), .mem_bus_data_out(mem_bus_data_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input completion_t c, input logic v);
        dram_valid_in = v;
        row_in        = c.row;
        bg_in         = c.bg;
        ba_in         = c.ba;
        col_in        = c.col;
        data_in       = c.data;
    endtask

    function automatic completion_t make(input int i);
        completion_t c;
        c.row  = 8'(8'h10 + i);
        c.bg   = 2'(i % 4);
        c.ba   = 1'(i % 2);
        c.col  = 4'(i);
        c.data = 64'(64'hD000 + i);
        return c;
    endfunction

    // Expected address: row at [14:7], bg at [6:5], ba at [4], col at [3:0].
    function automatic logic [PADDR_BITS-1:0] exp_addr(input completion_t c);
        return (PADDR_BITS'(c.row) << 7) | (PADDR_BITS'(c.bg) << 5) |
               (PADDR_BITS'(c.ba) << 4) | PADDR_BITS'(c.col);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        completion_t c;
        logic [7:0] rr;
        logic [1:0] rbg;
        logic [0:0] rba;
        logic [3:0] rcol;

        rst_in = 1'b1;
        mem_bus_ready_in = 1'b0;
        drive('0, 1'b0);

        #3;
        check("rst_valid", mem_bus_valid_out, 0);
        check("rst_ready", dram_ready_out, 1);
        check("rst_count", count_out, 0);
        check("rst_addr", mem_bus_addr_out, 0);
        check("rst_data", mem_bus_data_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Single completion: A5<<7 | 2<<5 | 1<<4 | 3 = 0x52D3.
        c = '{row: 8'hA5, bg: 2'd2, ba: 1'b1, col: 4'h3, data: 64'h1234};
        drive(c, 1'b1);
        #1;
        check("no_bypass", mem_bus_valid_out, 0);
        tick();
        dram_valid_in = 1'b0;
        check("single_valid", mem_bus_valid_out, 1);
        check("single_addr", mem_bus_addr_out, 19'h052D3);
        check("single_data", mem_bus_data_out, 64'h1234);
        check("single_count", count_out, 1);
        mem_bus_ready_in = 1'b1;
        tick();
        mem_bus_ready_in = 1'b0;
        check("single_pop_count", count_out, 0);
        check("single_pop_valid", mem_bus_valid_out, 0);
        check("empty_addr_mask", mem_bus_addr_out, 0);

        // Fill to DEPTH with the bus stalled, then offer a fifth.
        for (int i = 0; i < 4; i++) begin
            drive(make(i), 1'b1);
            tick();
        end
        drive(make(4), 1'b1);
        check("full_count", count_out, 4);
        check("full_ready", dram_ready_out, 0);
        tick();
        check("full_no_push", count_out, 4);
        check("full_stable_addr", mem_bus_addr_out, exp_addr(make(0)));
        check("full_stable_data", mem_bus_data_out, make(0).data);

        // Full with valid on both sides: pop only.
        mem_bus_ready_in = 1'b1;
        tick();
        dram_valid_in = 1'b0;
        check("full_pop_count", count_out, 3);
        check("full_pop_ready", dram_ready_out, 1);
        for (int i = 1; i < 4; i++) begin
            check("drain_addr", mem_bus_addr_out, exp_addr(make(i)));
            check("drain_data", mem_bus_data_out, make(i).data);
            tick();
        end
        mem_bus_ready_in = 1'b0;
        check("drain_count", count_out, 0);
        check("drain_valid", mem_bus_valid_out, 0);

        // Streaming push+pop, occupancy held at one.
        drive(make(20), 1'b1);
        tick();
        mem_bus_ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(make(21 + k), 1'b1);
            check("stream_data", mem_bus_data_out, make(20 + k).data);
            tick();
            check("stream_count", count_out, 1);
        end
        dram_valid_in = 1'b0;
        check("stream_last", mem_bus_data_out, make(30).data);
        tick();
        mem_bus_ready_in = 1'b0;
        check("stream_empty", count_out, 0);

        // Reset mid-cycle with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(make(40 + i), 1'b1);
            tick();
        end
        dram_valid_in = 1'b0;
        check("pre_rst_count", count_out, 3);
        #2;
        rst_in = 1'b1;
        #1;
        check("midrst_valid", mem_bus_valid_out, 0);
        check("midrst_count", count_out, 0);
        check("midrst_ready", dram_ready_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        mem_bus_ready_in = 1'b1;
        tick();
        tick();
        check("post_rst_valid", mem_bus_valid_out, 0);
        check("post_rst_addr", mem_bus_addr_out, 0);
        check("post_rst_data", mem_bus_data_out, 0);
        mem_bus_ready_in = 1'b0;
        drive(make(50), 1'b1);
        tick();
        dram_valid_in = 1'b0;
        check("post_rst_fresh", mem_bus_data_out, make(50).data);
        check("post_rst_fresh_count", count_out, 1);
        mem_bus_ready_in = 1'b1;
        tick();

        // Random round trip through the scheduler's field mapping.
        for (int n = 0; n < 1000; n++) begin
            rr   = 8'($urandom);
            rbg  = 2'($urandom);
            rba  = 1'($urandom);
            rcol = 4'($urandom);
            c = '{row: rr, bg: rbg, ba: rba, col: rcol, data: 64'(n)};
            mem_bus_ready_in = 1'b0;
            drive(c, 1'b1);
            tick();
            dram_valid_in = 1'b0;
            check("rt_fields",
                  {mem_bus_addr_out[LOWER_BITS +: 8], mem_bus_addr_out[6:5],
                   mem_bus_addr_out[4], mem_bus_addr_out[3:0]},
                  {rr, rbg, rba, rcol});
            check("rt_upper", mem_bus_addr_out[18:15], 4'h0);
            mem_bus_ready_in = 1'b1;
            tick();
        end
        check("final_count", count_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
